// File: rtl/serial_adder.sv
// Bit-serial adder: one full adder (two half adders plus an OR) reused over
// WIDTH cycles, with a start/busy/done handshake and held, registered results.

module half_adder (
  input  logic a_i,
  input  logic b_i,
  output logic s_o,
  output logic c_o
);
  assign s_o = a_i ^ b_i;
  assign c_o = a_i & b_i;
endmodule

// state | meaning
// IDLE  | waiting for start; sum_o/cout_o hold the last result
// RUN   | one operand bit per cycle, LSB first; busy_o high
// DONE  | done_o high for exactly one cycle, then back to IDLE
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             cin_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] sum_o,
  output logic             cout_o
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] a_q, b_q, res_q, res_d, sum_q;
  logic [CW-1:0]    cnt_q;
  logic             carry_q, cout_q, busy_q, done_q;
  logic             s1, c1, c2, fa_sum, fa_cout;

  half_adder u_ha1 (.a_i(a_q[0]), .b_i(b_q[0]),  .s_o(s1),     .c_o(c1));
  half_adder u_ha2 (.a_i(s1),     .b_i(carry_q), .s_o(fa_sum), .c_o(c2));

  assign fa_cout = c1 | c2;

  // New bit enters at the MSB so that after WIDTH shifts bit 0 is the LSB.
  always_comb begin
    res_d = res_q >> 1;
    res_d[WIDTH-1] = fa_sum;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start_i) begin
            a_q     <= a_i;
            b_q     <= b_i;
            carry_q <= cin_i;
            cnt_q   <= '0;
            res_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end
        end
        RUN: begin
          a_q     <= a_q >> 1;
          b_q     <= b_q >> 1;
          carry_q <= fa_cout;
          res_q   <= res_d;
          cnt_q   <= cnt_q + CW'(1);
          if (cnt_q == LAST) begin
            sum_q   <= res_d;
            cout_q  <= fa_cout;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy_o = busy_q;
  assign done_o = done_q;
  assign sum_o  = sum_q;
  assign cout_o = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder (WIDTH=8): handshake timing, overflow,
// start-in-RUN, mid-operation reset, back-to-back starts and a random sweep.

module tb_serial_adder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [7:0] a, b;
  logic       cin;
  logic       busy, done, cout;
  logic [7:0] sum;

  int total = 0;
  int bad   = 0;

  serial_adder #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start), .a_i(a), .b_i(b), .cin_i(cin),
    .busy_o(busy), .done_o(done), .sum_o(sum), .cout_o(cout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [8:0] obs, input logic [8:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full single-pulse operation with timing checks on every edge.
  task automatic op(input logic [7:0] oa, input logic [7:0] ob, input logic oc,
                    input logic [7:0] es, input logic ec, input string tag);
    logic [7:0] prev_sum;
    logic       prev_cout;
    prev_sum  = sum;
    prev_cout = cout;
    @(negedge clk);
    start = 1'b1; a = oa; b = ob; cin = oc;
    tick();
    chk({tag, "_busy_e0"}, busy, 1);
    @(negedge clk);
    start = 1'b0; a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom);
    for (int k = 1; k < 8; k++) begin
      tick();
      chk({tag, "_busy_run"}, busy, 1);
      chk({tag, "_done_run"}, done, 0);
      chk({tag, "_sum_hold"}, {prev_cout, prev_sum}, {cout, sum});
    end
    tick();
    chk({tag, "_done"}, done, 1);
    chk({tag, "_busy_end"}, busy, 0);
    chk({tag, "_sum"}, sum, es);
    chk({tag, "_cout"}, cout, ec);
    tick();
    chk({tag, "_done_drop"}, done, 0);
    chk({tag, "_sum_held"}, sum, es);
    chk({tag, "_cout_held"}, cout, ec);
  endtask

  initial begin
    logic [8:0] ref_v;
    logic [7:0] ra, rb;
    logic       rc;
    int         cyc;
    int         ndone;

    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0;
    #23;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_sum",  sum,  0);
    chk("rst_cout", cout, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    op(8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, "basic");
    op(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, "ovf1");
    op(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, "ovf2");
    op(8'h00, 8'h00, 1'b1, 8'h01, 1'b0, "cin_only");

    // start re-asserted while RUN must be ignored
    @(negedge clk);
    start = 1'b1; a = 8'h10; b = 8'h20; cin = 1'b0;
    tick();
    @(negedge clk);
    start = 1'b0;
    tick(); tick();
    @(negedge clk);
    start = 1'b1; a = 8'hAA; b = 8'h55; cin = 1'b1;
    tick();
    @(negedge clk);
    start = 1'b0;
    ndone = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (done) begin
        ndone++;
        chk("srun_sum", sum, 8'h30);
        chk("srun_cout", cout, 0);
      end
      if (k > 8) chk("srun_idle", busy, 0);
    end
    chk("srun_ndone", 9'(ndone), 1);

    // reset mid-operation
    @(negedge clk);
    start = 1'b1; a = 8'h0F; b = 8'h01; cin = 1'b0;
    tick();
    @(negedge clk);
    start = 1'b0;
    tick(); tick(); tick();
    #2 rst_n = 1'b0;
    #1;
    chk("mrst_busy", busy, 0);
    chk("mrst_done", done, 0);
    chk("mrst_sum",  sum,  0);
    chk("mrst_cout", cout, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (done || busy) ndone++;
    end
    chk("mrst_quiet", 9'(ndone), 0);
    op(8'h02, 8'h03, 1'b0, 8'h05, 1'b0, "post_rst");

    // start held high: back-to-back operations every WIDTH+2 cycles
    @(negedge clk);
    start = 1'b1; a = 8'h80; b = 8'h80; cin = 1'b0;
    for (int p = 0; p < 3; p++) begin
      cyc = 0;
      do begin
        tick();
        cyc++;
      end while (!done && cyc < 30);
      chk("held_gap", 9'(cyc), (p == 0) ? 9'd9 : 9'd10);
      chk("held_sum", sum, 8'h00);
      chk("held_cout", cout, 1);
    end
    @(negedge clk);
    start = 1'b0;
    tick(); tick();
    chk("held_stop", busy, 0);

    for (int n = 0; n < 500; n++) begin
      ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
      ref_v = {1'b0, ra} + {1'b0, rb} + {8'b0, rc};
      op(ra, rb, rc, ref_v[7:0], ref_v[8], "rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout observed=running expected=finished");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

endmodule
